mem2_load_stage: RTL and testbench

- Parametrised successor of the MEM2 pipeline stage: a single-entry stage register between MEM and WB with a valid/ready handshake on both sides.
- Waits for a variable-latency D-cache read response and aligns load data for LB/LBU/LH/LHU/LW/LWL/LWR.
- Selects the write-back result and drives forwarding outputs with a result-valid qualifier.
- Flushed loads whose responses are still outstanding have those responses discarded in order.

---
 rtl/cpu_mem_pkg.sv | 38 +++
 rtl/load_align.sv | 45 ++++
 rtl/mem2_load_stage.sv | 167 ++++++++++++++++
 tb/tb_mem2_load_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared memory-pipeline types: load kinds, write-back select, MEM2 stage
// states, and the load context that the stage holds while a read is in flight.
package cpu_mem_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    LT_NONE = 3'd0,
    LB      = 3'd1,
    LBU     = 3'd2,
    LH      = 3'd3,
    LHU     = 3'd4,
    LW      = 3'd5,
    LWL     = 3'd6,
    LWR     = 3'd7
  } load_type_e;

  typedef enum logic [1:0] {
    WB_PC   = 2'b00,
    WB_ALU  = 2'b01,
    WB_OUTB = 2'b10,
    WB_LOAD = 2'b11
  } wbsel_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    WAIT  = 2'd2
  } mem2_state_e;

  // Everything the aligner needs once the D-cache word shows up.
  typedef struct packed {
    load_type_e        load_type;
    logic [1:0]        addr_lo;
    logic [DATA_W-1:0] rt;
  } load_ctx_t;

endpackage

// File: rtl/load_align.sv
// Combinational little-endian load aligner for LB/LBU/LH/LHU/LW/LWL/LWR.
// Ports: load_type  - kind of load
//        addr       - byte offset within the word
//        rdata      - word returned by the D-cache
//        rt         - current rt value (merge source for LWL/LWR)
//        result_c   - aligned 32-bit write-back value
module load_align
  import cpu_mem_pkg::*;
(
  input  load_type_e        load_type,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] rt,
  output logic [DATA_W-1:0] result_c
);

  logic [4:0]        sh_lo;
  logic [4:0]        sh_hi;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] lwl_mask;
  logic [DATA_W-1:0] lwr_mask;

  always_comb begin
    sh_lo    = {addr, 3'b000};
    sh_hi    = {2'(2'd3 - addr), 3'b000};
    byte_v   = 8'(rdata >> sh_lo);
    half_v   = addr[1] ? rdata[31:16] : rdata[15:0];
    // Masks mark the bytes supplied by memory; the rest come from rt.
    lwl_mask = {DATA_W{1'b1}} << sh_hi;
    lwr_mask = {DATA_W{1'b1}} >> sh_lo;
    result_c = rdata;
    case (load_type)
      LB:      result_c = {{24{byte_v[7]}}, byte_v};
      LBU:     result_c = {24'd0, byte_v};
      LH:      result_c = {{16{half_v[15]}}, half_v};
      LHU:     result_c = {16'd0, half_v};
      LW:      result_c = rdata;
      LWL:     result_c = (rdata << sh_hi) | (rt & ~lwl_mask);
      LWR:     result_c = (rdata >> sh_lo) | (rt & ~lwr_mask);
      default: result_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem2_load_stage.sv
// MEM2 stage: single-entry register between MEM and WB. Waits for in-order
// D-cache read responses, aligns load data, selects the write-back value and
// drives forwarding. Responses owed to flushed loads are counted and dropped.
// Ports: clk/resetn         - clock, async active-low reset
//        flush              - kill held entry, ignore in_valid this cycle
//        in_*               - MEM-side valid/ready and instruction fields
//        dc_rvalid/dc_rdata - D-cache read response
//        out_*              - WB-side valid/ready and held fields
//        fwd_*              - forwarding destination, write flag, result
//        discard_full       - discard counter saturated, loads refused
module mem2_load_stage
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REG_IDX_W   = 5,
  parameter int unsigned PC_LINK_OFS = 8,
  parameter int unsigned MAX_DISCARD = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_pc,
  input  logic [31:0]          in_alu_out,
  input  logic [31:0]          in_outb,
  input  logic [REG_IDX_W-1:0] in_dst,
  input  logic                 in_reg_wr,
  input  logic [1:0]           in_wbsel,
  input  logic [2:0]           in_load_type,
  input  logic                 dc_rvalid,
  input  logic [31:0]          dc_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_pc,
  output logic [31:0]          out_result,
  output logic [REG_IDX_W-1:0] out_dst,
  output logic                 out_reg_wr,
  output logic [REG_IDX_W-1:0] fwd_dst,
  output logic                 fwd_reg_wr,
  output logic                 fwd_result_valid,
  output logic [31:0]          fwd_result,
  output logic                 discard_full
);

  localparam int unsigned CNT_W = $clog2(MAX_DISCARD + 1);

  mem2_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [REG_IDX_W-1:0] dst_q, dst_d;
  logic                 reg_wr_q, reg_wr_d;
  load_ctx_t            ctx_q, ctx_d;
  logic [DATA_W-1:0]    result_q, result_d;

  logic              is_load_c;
  logic              discard_full_c;
  logic              accept_c;
  logic              own_rsp_c;
  logic [DATA_W-1:0] issue_result_c;
  logic [DATA_W-1:0] aligned_c;

  load_align u_align (
    .load_type (ctx_q.load_type),
    .addr      (ctx_q.addr_lo),
    .rdata     (dc_rdata),
    .rt        (ctx_q.rt),
    .result_c  (aligned_c)
  );

  // Handshake and response classification.
  always_comb begin
    is_load_c      = (wbsel_e'(in_wbsel) == WB_LOAD);
    discard_full_c = (cnt_q == CNT_W'(MAX_DISCARD));
    in_ready       = ((state_q == EMPTY) || ((state_q == FULL) && out_ready))
                     && !(discard_full_c && is_load_c);
    accept_c       = in_valid && in_ready && !flush;
    // With nothing owed to flushed loads, a response belongs to the held load.
    own_rsp_c      = dc_rvalid && (cnt_q == '0);
  end

  // Write-back value known at issue time; loads fill it in on response.
  always_comb begin
    case (wbsel_e'(in_wbsel))
      WB_PC:   issue_result_c = DATA_W'(in_pc + ADDR_W'(PC_LINK_OFS));
      WB_ALU:  issue_result_c = in_alu_out;
      WB_OUTB: issue_result_c = in_outb;
      default: issue_result_c = '0;
    endcase
  end

  // Next-state, discard counter and held-field update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    dst_d    = dst_q;
    reg_wr_d = reg_wr_q;
    ctx_d    = ctx_q;
    result_d = result_q;

    if (dc_rvalid && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (flush) begin
      state_d = EMPTY;
      if (state_q == WAIT) begin
        if (!dc_rvalid) begin
          if (!discard_full_c) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // Either this is the waited response, or drop and new debt cancel.
          cnt_d = cnt_q;
        end
      end
    end else if (accept_c) begin
      state_d  = is_load_c ? WAIT : FULL;
      pc_d     = in_pc;
      dst_d    = in_dst;
      reg_wr_d = in_reg_wr;
      ctx_d    = '{load_type: load_type_e'(in_load_type),
                   addr_lo:   in_alu_out[1:0],
                   rt:        in_outb};
      result_d = issue_result_c;
    end else if ((state_q == WAIT) && own_rsp_c) begin
      state_d  = FULL;
      result_d = aligned_c;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // State and held-field registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      pc_q     <= '0;
      dst_q    <= '0;
      reg_wr_q <= 1'b0;
      ctx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      dst_q    <= dst_d;
      reg_wr_q <= reg_wr_d;
      ctx_q    <= ctx_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    out_valid        = (state_q == FULL);
    out_pc           = pc_q;
    out_result       = result_q;
    out_dst          = dst_q;
    out_reg_wr       = reg_wr_q && (state_q == FULL);
    fwd_dst          = dst_q;
    fwd_reg_wr       = reg_wr_q && (state_q != EMPTY);
    fwd_result_valid = (state_q != WAIT);
    fwd_result       = result_q;
    discard_full     = discard_full_c;
  end

endmodule

// File: tb/tb_mem2_load_stage.sv
`timescale 1ns/1ps
module tb_mem2_load_stage;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned N_RAND    = 600;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_W-1:0]    in_pc;
  logic [31:0]          in_alu_out;
  logic [31:0]          in_outb;
  logic [REG_IDX_W-1:0] in_dst;
  logic                 in_reg_wr;
  logic [1:0]           in_wbsel;
  logic [2:0]           in_load_type;
  logic                 dc_rvalid;
  logic [31:0]          dc_rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [ADDR_W-1:0]    out_pc;
  logic [31:0]          out_result;
  logic [REG_IDX_W-1:0] out_dst;
  logic                 out_reg_wr;
  logic [REG_IDX_W-1:0] fwd_dst;
  logic                 fwd_reg_wr;
  logic                 fwd_result_valid;
  logic [31:0]          fwd_result;
  logic                 discard_full;

  mem2_load_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_alu_out(in_alu_out), .in_outb(in_outb), .in_dst(in_dst),
    .in_reg_wr(in_reg_wr), .in_wbsel(in_wbsel), .in_load_type(in_load_type),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_result(out_result), .out_dst(out_dst), .out_reg_wr(out_reg_wr),
    .fwd_dst(fwd_dst), .fwd_reg_wr(fwd_reg_wr),
    .fwd_result_valid(fwd_result_valid), .fwd_result(fwd_result),
    .discard_full(discard_full)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { logic [31:0] pc; logic [31:0] res; logic [4:0] dst; logic wr; } exp_t;
  typedef struct { logic [31:0] data; int due; } rsp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] wbsel, input logic [2:0] lt, input logic [31:0] pc,
                          input logic [31:0] alu, input logic [31:0] outb,
                          input logic [4:0] dst, input logic wr);
    in_valid = 1'b1; in_wbsel = wbsel; in_load_type = lt; in_pc = pc;
    in_alu_out = alu; in_outb = outb; in_dst = dst; in_reg_wr = wr;
  endtask

  // Reference aligner working byte by byte on the little-endian word.
  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [1:0] a,
                                           input logic [31:0] rd, input logic [31:0] rt);
    logic [7:0]  b [4];
    logic [7:0]  r [4];
    logic [7:0]  o [4];
    logic [15:0] h;
    int k;
    k = int'(a);
    for (int i = 0; i < 4; i++) begin
      b[i] = rd[8*i +: 8];
      r[i] = rt[8*i +: 8];
      o[i] = r[i];
    end
    case (lt)
      3'd1: return {{24{b[k][7]}}, b[k]};
      3'd2: return {24'd0, b[k]};
      3'd3: begin h = {b[2*(k/2)+1], b[2*(k/2)]}; return {{16{h[15]}}, h}; end
      3'd4: begin h = {b[2*(k/2)+1], b[2*(k/2)]}; return {16'd0, h}; end
      3'd6: begin
        for (int i = 0; i < 4; i++) if (i >= 3 - k) o[i] = b[i - (3 - k)];
        return {o[3], o[2], o[1], o[0]};
      end
      3'd7: begin
        for (int i = 0; i < 4; i++) if (i <= 3 - k) o[i] = b[i + k];
        return {o[3], o[2], o[1], o[0]};
      end
      default: return rd;
    endcase
  endfunction

  // Issue one load into an empty stage, answer it after lat cycles, check it.
  task automatic do_load(input string tag, input logic [2:0] lt, input logic [31:0] addr,
                         input logic [31:0] rt, input logic [31:0] rdata, input int lat,
                         input logic [31:0] exp_v);
    int low;
    drive_op(2'b11, lt, 32'h0000_0400, addr, rt, 5'd7, 1'b1);
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    low = 0;
    for (int c = 1; c <= lat; c++) begin
      dc_rvalid = (c == lat);
      dc_rdata  = rdata;
      #1;
      if (!fwd_result_valid) low++;
      if (c == 1) chk({tag, "_wait_fwd_wr"}, fwd_reg_wr, 1);
      tick();
    end
    dc_rvalid = 1'b0;
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_result"}, out_result, exp_v);
    chk({tag, "_fwd_low_cycles"}, low, lat);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t expq [$];
    rsp_t rspq [$];
    exp_t e;
    rsp_t r;
    logic occ, pend, n_occ, n_pend, exp_rdy, exp_vld, acc;
    int   c;

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_alu_out = '0;
    in_outb = '0; in_dst = '0; in_reg_wr = 1'b0; in_wbsel = 2'b00; in_load_type = 3'd0;
    dc_rvalid = 1'b0; dc_rdata = '0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_reg_wr", out_reg_wr, 0);
    chk("rst_fwd_reg_wr", fwd_reg_wr, 0);
    chk("rst_discard_full", discard_full, 0);
    resetn = 1'b1;
    tick();

    // Non-load ops, back to back, then a WB stall.
    drive_op(2'b01, 3'd0, 32'h100, 32'h1234, 32'h0, 5'd3, 1'b1);
    #1 chk("alu_in_ready", in_ready, 1);
    tick();
    chk("alu_out_valid", out_valid, 1);
    chk("alu_result", out_result, 32'h1234);
    chk("alu_dst", out_dst, 3);
    chk("alu_out_reg_wr", out_reg_wr, 1);
    chk("alu_fwd_valid", fwd_result_valid, 1);
    drive_op(2'b00, 3'd0, 32'h200, 32'h0, 32'h0, 5'd4, 1'b1);
    #1 chk("b2b_in_ready", in_ready, 1);
    tick();
    chk("link_result", out_result, 32'h208);
    chk("link_pc", out_pc, 32'h200);
    drive_op(2'b10, 3'd0, 32'h300, 32'h0, 32'hCAFE_F00D, 5'd9, 1'b0);
    tick();
    chk("outb_result", out_result, 32'hCAFE_F00D);
    chk("outb_no_reg_wr", out_reg_wr, 0);
    chk("outb_no_fwd_wr", fwd_reg_wr, 0);
    drive_op(2'b01, 3'd0, 32'h310, 32'h77, 32'h0, 5'd2, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("stall_in_ready", in_ready, 0);
    tick();
    chk("stall_hold_valid", out_valid, 1);
    chk("stall_hold_result", out_result, 32'h77);
    out_ready = 1'b1;
    tick();
    chk("drain_out_valid", out_valid, 0);

    // Loads with the aligner's corner cases.
    do_load("lb", 3'd1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 3, 32'hFFFF_FF80);
    do_load("lwl", 3'd6, 32'h0000_2001, 32'hAABB_CCDD, 32'h1122_3344, 1, 32'h3344_CCDD);
    do_load("lwr", 3'd7, 32'h0000_2001, 32'hAABB_CCDD, 32'h1122_3344, 2, 32'hAA11_2233);
    do_load("lbu", 3'd2, 32'h0000_0002, 32'h0, 32'h0091_0000,
            1, ref_load(3'd2, 2'd2, 32'h0091_0000, 32'h0));
    do_load("lh", 3'd3, 32'h0000_0002, 32'h0, 32'h8001_7FFF,
            2, ref_load(3'd3, 2'd2, 32'h8001_7FFF, 32'h0));
    do_load("lhu", 3'd4, 32'h0000_0000, 32'h0, 32'h8001_F00F,
            1, ref_load(3'd4, 2'd0, 32'h8001_F00F, 32'h0));
    do_load("lw", 3'd5, 32'h0000_0000, 32'h0, 32'h1357_9BDF, 4, 32'h1357_9BDF);

    // Flush a waiting load, reissue, first response is dropped.
    drive_op(2'b11, 3'd5, 32'h500, 32'h40, 32'h0, 5'd6, 1'b1);
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_empties", fwd_reg_wr, 0);
    drive_op(2'b11, 3'd5, 32'h504, 32'h80, 32'h0, 5'd6, 1'b1);
    #1 chk("flush_reissue_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; dc_rvalid = 1'b1; dc_rdata = 32'h0000_DEAD;
    tick();
    dc_rvalid = 1'b0;
    chk("discard_not_valid", out_valid, 0);
    chk("discard_fwd_low", fwd_result_valid, 0);
    dc_rvalid = 1'b1; dc_rdata = 32'h0000_005A;
    tick();
    dc_rvalid = 1'b0;
    chk("discard_then_valid", out_valid, 1);
    chk("discard_then_result", out_result, 32'h5A);
    chk("discard_count_clear", discard_full, 0);
    tick();

    // Saturate the discard counter.
    for (int i = 0; i < 3; i++) begin
      drive_op(2'b11, 3'd5, 32'h600, 32'h0, 32'h0, 5'd1, 1'b1);
      #1 chk("sat_load_ready", in_ready, 1);
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    chk("sat_full", discard_full, 1);
    in_valid = 1'b0; in_wbsel = 2'b11;
    #1 chk("sat_load_refused", in_ready, 0);
    in_wbsel = 2'b01;
    #1 chk("sat_alu_allowed", in_ready, 1);
    in_wbsel = 2'b11; dc_rvalid = 1'b1;
    tick();
    chk("sat_drop_clears_full", discard_full, 0);
    chk("sat_load_ready_again", in_ready, 1);
    tick();
    tick();
    dc_rvalid = 1'b0;
    chk("sat_drained_no_valid", out_valid, 0);

    // Reset while a load waits.
    drive_op(2'b11, 3'd5, 32'h700, 32'h44, 32'h0, 5'd12, 1'b1);
    tick();
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst_wait_pc", out_pc, 0);
    chk("rst_wait_fwd_wr", fwd_reg_wr, 0);
    chk("rst_wait_fwd_valid", fwd_result_valid, 1);
    tick();
    resetn = 1'b1;
    #1 chk("rst_release_ready", in_ready, 1);
    dc_rvalid = 1'b1; dc_rdata = 32'h0000_0BAD;
    tick();
    dc_rvalid = 1'b0;
    chk("stale_rsp_ignored", out_valid, 0);
    chk("stale_rsp_no_count", discard_full, 0);

    // Random traffic against a transaction-level model.
    occ = 1'b0; pend = 1'b0;
    c = 0;
    while ((c < int'(N_RAND) || expq.size() != 0) && c < int'(N_RAND) + 100) begin
      out_ready = ($urandom_range(0, 3) != 0);
      dc_rvalid = 1'b0;
      dc_rdata  = $urandom;
      if (rspq.size() != 0 && rspq[0].due <= c) begin
        dc_rvalid = 1'b1;
        dc_rdata  = rspq[0].data;
      end
      in_valid     = (c < int'(N_RAND)) && ($urandom_range(0, 1) == 1);
      in_wbsel     = 2'($urandom_range(0, 3));
      in_load_type = 3'($urandom_range(1, 7));
      in_pc        = $urandom;
      in_alu_out   = $urandom;
      in_outb      = $urandom;
      in_dst       = 5'($urandom);
      in_reg_wr    = 1'($urandom);
      if (in_load_type == 3'd3 || in_load_type == 3'd4) in_alu_out[0] = 1'b0;
      if (in_load_type == 3'd5) in_alu_out[1:0] = 2'b00;
      #1;
      exp_rdy = !occ || (!pend && out_ready);
      exp_vld = occ && !pend;
      chk("rnd_in_ready", in_ready, exp_rdy);
      chk("rnd_out_valid", out_valid, exp_vld);
      chk("rnd_fwd_valid", fwd_result_valid, !pend);
      if (exp_vld) begin
        chk("rnd_result", out_result, expq[0].res);
        chk("rnd_dst", out_dst, expq[0].dst);
        chk("rnd_pc", out_pc, expq[0].pc);
        chk("rnd_reg_wr", out_reg_wr, expq[0].wr);
        if (out_ready) void'(expq.pop_front());
      end
      acc = in_valid && exp_rdy;
      if (acc) begin
        e.pc = in_pc; e.dst = in_dst; e.wr = in_reg_wr;
        case (in_wbsel)
          2'b00:   e.res = in_pc + 32'd8;
          2'b01:   e.res = in_alu_out;
          2'b10:   e.res = in_outb;
          default: begin
            r.data = $urandom;
            r.due  = c + int'($urandom_range(1, 4));
            rspq.push_back(r);
            e.res = ref_load(in_load_type, in_alu_out[1:0], r.data, in_outb);
          end
        endcase
        expq.push_back(e);
      end
      if (dc_rvalid) void'(rspq.pop_front());
      n_occ = occ; n_pend = pend;
      if (exp_vld && out_ready) n_occ = 1'b0;
      if (dc_rvalid) n_pend = 1'b0;
      if (acc) begin n_occ = 1'b1; n_pend = (in_wbsel == 2'b11); end
      occ = n_occ; pend = n_pend;
      tick();
      c++;
    end
    in_valid = 1'b0; dc_rvalid = 1'b0;
    chk("rnd_drain_complete", 32'(expq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
